// File: rtl/ram_fifo_pkg.sv
// Shared defaults and grant encoding for the RAM-backed FIFO controller.
// Optional error counter is enabled by defining FIFO_ERR_CNT_EN.
package ram_fifo_pkg;

  localparam int ADDR_LINES_DEF = 10;
  localparam int LOC_SIZE_DEF   = 32;
  localparam int ERR_CNT_W      = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter for the single RAM port.
// Priority toggles only when both requesters collide.
module rr_arb2
  import ram_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic wreq,
  input  logic rreq,
  output gnt_e grant,
  output logic wr_avail
);

  logic r_last_wr;

  // a write can only lose when a read competes and the write went last
  assign wr_avail = !(rreq && r_last_wr);

  // grant the single RAM op for this cycle
  always_comb begin
    grant = GNT_NONE;
    if (wreq && rreq)
      grant = r_last_wr ? GNT_RD : GNT_WR;
    else if (wreq)
      grant = GNT_WR;
    else if (rreq)
      grant = GNT_RD;
  end

  // remember who won the last collision
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last_wr <= 1'b0;
    else if (wreq && rreq)
      r_last_wr <= ~r_last_wr;
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a single-port synchronous RAM, head word in RAM output reg.
// Define FIFO_ERR_CNT_EN to add the saturating blocked-push counter err_cnt.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_LINES = ADDR_LINES_DEF,
  parameter int LOC_SIZE   = LOC_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_valid,
  input  logic [LOC_SIZE-1:0]   push_data,
  output logic                  push_ready,
  output logic                  pop_valid,
  output logic [LOC_SIZE-1:0]   pop_data,
  input  logic                  pop_ready,
  output logic [ADDR_LINES:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  mem_wr,
  output logic                  mem_en,
  output logic [ADDR_LINES-1:0] mem_wr_addr,
  output logic [ADDR_LINES-1:0] mem_rd_addr,
  output logic [LOC_SIZE-1:0]   mem_wr_data,
  input  logic [LOC_SIZE-1:0]   mem_rd_data
`ifdef FIFO_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

  localparam int CW    = ADDR_LINES + 1;
  localparam int DEPTH = 2 ** ADDR_LINES;

  logic [ADDR_LINES-1:0] r_wptr;
  logic [ADDR_LINES-1:0] r_rptr;
  logic [CW-1:0]         r_ram_cnt;
  logic                  r_pop_valid;

  logic w_full;
  logic w_wreq;
  logic w_rreq;
  logic w_wr_avail;
  logic w_wr;
  logic w_rd;
  gnt_e w_grant;

  assign w_full = (r_ram_cnt == CW'(DEPTH));

  // requests are suppressed in reset so no RAM op leaks out
  assign w_wreq = rst_n && push_valid && !w_full;
  assign w_rreq = rst_n && (r_ram_cnt != '0)
               && (!r_pop_valid || pop_ready);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wreq     (w_wreq),
    .rreq     (w_rreq),
    .grant    (w_grant),
    .wr_avail (w_wr_avail)
  );

  assign w_wr = (w_grant == GNT_WR);
  assign w_rd = (w_grant == GNT_RD);

  // ready does not look at push_valid: only fill state and read demand
  assign push_ready = rst_n && !w_full && w_wr_avail;

  assign pop_valid = r_pop_valid;
  assign pop_data  = mem_rd_data;
  assign full      = w_full;
  assign count     = r_ram_cnt + CW'(r_pop_valid);
  assign empty     = (count == '0);

  assign mem_en      = w_wr || w_rd;
  assign mem_wr      = w_wr;
  assign mem_wr_addr = r_wptr;
  assign mem_rd_addr = r_rptr;
  assign mem_wr_data = push_data;

  // pointers and RAM occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_rd)
        r_rptr <= r_rptr + 1'b1;
      r_ram_cnt <= r_ram_cnt + CW'(w_wr) - CW'(w_rd);
    end
  end

  // head valid follows a read and drops when popped without refill
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pop_valid <= 1'b0;
    else if (w_rd)
      r_pop_valid <= 1'b1;
    else if (r_pop_valid && pop_ready)
      r_pop_valid <= 1'b0;
  end

`ifdef FIFO_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign err_cnt = r_err_cnt;

  // count cycles where a push is blocked by a full FIFO, saturating
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (push_valid && w_full && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_LINES, default 10, RAM address width; depth DEPTH = 2**ADDR_LINES.
REQ-002 SHALL have parameter LOC_SIZE, default 32, data word width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports push_valid input 1, push_data input LOC_SIZE, push_ready output 1  write-side handshake.
REQ-006 SHALL have ports pop_valid output 1, pop_data output LOC_SIZE, pop_ready input 1  read-side handshake.
REQ-007 SHALL have ports count output ADDR_LINES+1, full output 1, empty output 1  occupancy status.
REQ-008 SHALL have ports mem_wr, mem_en output 1, mem_wr_addr and mem_rd_addr output ADDR_LINES, mem_wr_data output LOC_SIZE, mem_rd_data input LOC_SIZE.
REQ-008a mem_* SHALL drive a single-port synchronous RAM: op only when mem_en=1, write when mem_wr=1, else read; read data registered, 1-cycle latency, held until the next read.

Function
REQ-009 Push fire = push_valid & push_ready; pop fire = pop_valid & pop_ready.
REQ-010 ram_cnt (words in RAM not yet read) SHALL be 0..DEPTH; full = (ram_cnt==DEPTH); count = ram_cnt + pop_valid; empty = (count==0).
REQ-011 Write request wreq = push_valid & !full; read request rreq = (ram_cnt!=0) & (!pop_valid | pop_ready).
REQ-012 At most one RAM op per cycle; rreq alone -> read; wreq alone -> write; both -> round-robin grant bit last_wr: grant read if last_wr=1, else write; toggle last_wr only on conflict.
REQ-013 Write grant: mem_en=1, mem_wr=1, mem_wr_addr=wptr, mem_wr_data=push_data, push_ready=1; wptr wraps DEPTH-1 -> 0.
REQ-014 Read grant: mem_en=1, mem_wr=0, mem_rd_addr=rptr; rptr wraps DEPTH-1 -> 0; pop_valid=1 next cycle.
REQ-015 pop_data SHALL be mem_rd_data directly; a read SHALL never be issued while pop_valid=1 unless pop fires that cycle (head must not be overwritten).
REQ-016 pop_valid clears after pop fire with no read granted; stays 1 when pop fires and read granted (1 word/cycle streaming).
REQ-017 Latency push fire on empty FIFO -> pop_valid = 2 cycles.
REQ-018 Push when full: push_ready=0, no RAM op for write; pop when pop_valid=0 has no effect.
REQ-019 push_ready SHALL combinationally depend on push_valid-independent state plus pop_ready/pop_valid (documented combinational path); pop_valid SHALL be registered.
REQ-020 No RAM op: mem_en=0, mem_wr=0.

Reset
REQ-021 While rst_n=0 at a clock edge: wptr, rptr, ram_cnt=0; pop_valid=0; last_wr=0 (first conflict grants write).
REQ-022 While rst_n=0: push_ready=0, mem_en=0, mem_wr=0 combinationally; reset mid-transfer discards all contents, count=0 next cycle.

Configuration
REQ-023 With FIFO_ERR_CNT_EN defined: extra output err_cnt, 8 bits, counts cycles with push_valid=1 & full=1, saturates at 255, reset to 0.
REQ-024 Without FIFO_ERR_CNT_EN: no err_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-025 Package ram_fifo_pkg SHALL hold default ADDR_LINES/LOC_SIZE, the grant encoding (GNT_NONE, GNT_WR, GNT_RD) and ERR_CNT_W=8.
REQ-026 Two-requester round-robin arbiter SHALL be sub-module rr_arb2 (inputs wreq, rreq; output grant; owns last_wr).

Verification
REQ-027 Reset, push 0xA5A5A5A5 with pop_ready=0 -> pop_valid=1 two cycles later, pop_data=0xA5A5A5A5, count=1, empty=0.
REQ-028 ADDR_LINES=2, push 5 words 1..5 with pop_ready=0 -> 5 accepted (4 RAM + head), count=5, full=1, 6th push_ready=0; with FIFO_ERR_CNT_EN err_cnt increments per blocked cycle.
REQ-029 Continuous push and pop_ready=1 -> conflicts alternate grants write/read starting with write; data order preserved 1,2,3,...; no loss.
REQ-030 Fill, then drain with pop_ready=1 and no push -> one word per cycle, wptr/rptr wrap through 0, empty=1 after last pop.
REQ-031 Assert rst_n=0 for one cycle with count=3 -> next cycle count=0, pop_valid=0, mem_en=0; subsequent push 0x1 pops 0x1.
